freq_gate_counter: RTL and testbench



---
 rtl/freq_gate_counter.sv | 139 +++++++++++++
 tb/tb_freq_gate_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - gated rising-edge counter for an asynchronous input
// Counts synchronised sig_in rising edges over GATE_CYCLES clocks and latches a saturated result.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int          CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             overflow,
  output logic             valid
);

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [1:0]       settle_cnt_q, settle_cnt_d;
  logic [31:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic edge_det;
  logic sat;

  assign edge_det = s2_q & ~s3_q;
  assign sat      = (edge_cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      settle_cnt_q <= 2'd0;
      gate_cnt_q   <= 32'd0;
      edge_cnt_q   <= '0;
      ovf_acc_q    <= 1'b0;
      freq_q       <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_acc_q    <= ovf_acc_d;
      freq_q       <= freq_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    s1_d         = sig_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_acc_d    = ovf_acc_q;
    freq_d       = freq_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;

    case (state_q)
      SETTLE: begin
        // Lets the synchroniser flush so a high level at reset release is never counted.
        if (settle_cnt_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 2'd1;
        end
      end

      IDLE: begin
        gate_cnt_d = 32'd0;
        edge_cnt_d = '0;
        ovf_acc_d  = 1'b0;
        if (enable) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (!enable) begin
          state_d    = IDLE;
          gate_cnt_d = 32'd0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          // Terminal cycle: fold in its own edge, publish, and restart without a gap.
          valid_d    = 1'b1;
          freq_d     = (edge_det && !sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
          ovf_d      = ovf_acc_q | (edge_det & sat);
          gate_cnt_d = 32'd0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + 32'd1;
          if (edge_det) begin
            if (sat) begin
              ovf_acc_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - directed self-checking bench for freq_gate_counter
// Three instances: 100-cycle/12-bit, 10000-cycle/12-bit, 100-cycle/4-bit for saturation at the terminal cycle.
module tb_freq_gate_counter;

  logic        clk;
  logic        rst_n;
  logic        en_a, en_b, en_c;
  logic        sig_in;
  logic        sig_man;
  logic [11:0] freq_a, freq_b;
  logic [3:0]  freq_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        valid_a, valid_b, valid_c;

  int errors = 0;
  int checks = 0;
  int sq_per = 0;
  int sq_ph  = 0;
  logic sq   = 1'b0;
  int n;
  int vcount;

  freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(12)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .sig_in(sig_in),
    .freq_out(freq_a), .overflow(ovf_a), .valid(valid_a)
  );

  freq_gate_counter #(.GATE_CYCLES(10000), .CNT_W(12)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .sig_in(sig_in),
    .freq_out(freq_b), .overflow(ovf_b), .valid(valid_b)
  );

  freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .sig_in(sig_in),
    .freq_out(freq_c), .overflow(ovf_c), .valid(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave of sq_per clocks, updated on the falling edge.
  always @(negedge clk) begin
    if (sq_per > 1) begin
      sq_ph = (sq_ph + 1) % sq_per;
      sq    = (sq_ph < sq_per / 2);
    end else begin
      sq = 1'b0;
    end
  end

  assign sig_in = (sq_per > 1) ? sq : sig_man;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic vsel(input int sel);
    case (sel)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  task automatic wait_valid(input int sel, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!vsel(sel) && cnt < budget);
    chk("valid_seen", {31'd0, vsel(sel)}, 32'd1);
  endtask

  function automatic logic pat(input int t);
    if (t == 98 || t == 198) return 1'b1;
    if (t >= 10 && t < 64) return ((t - 10) % 4) < 2;
    if (t >= 110 && t < 170) return ((t - 110) % 4) < 2;
    return 1'b0;
  endfunction

  initial begin
    rst_n   = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    en_c    = 1'b0;
    sig_man = 1'b0;
    repeat (3) tick();
    chk("rst_freq", {20'd0, freq_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);

    // sig_in high across reset release with enable already asserted
    sig_man = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    en_a  = 1'b1;
    wait_valid(0, 200, n);
    chk("hi_first_latency", n, 104);
    chk("hi_freq", {20'd0, freq_a}, 32'd0);
    chk("hi_ovf", {31'd0, ovf_a}, 32'd0);
    tick();
    chk("valid_one_cycle", {31'd0, valid_a}, 32'd0);
    wait_valid(0, 200, n);
    chk("hi_spacing", n, 99);
    chk("hi_freq2", {20'd0, freq_a}, 32'd0);

    // period-10 square wave, five back-to-back windows
    sq_per = 10;
    wait_valid(0, 200, n);
    for (int w = 0; w < 5; w++) begin
      wait_valid(0, 200, n);
      chk("p10_spacing", n, 100);
      chk("p10_freq", {20'd0, freq_a}, 32'd10);
      chk("p10_ovf", {31'd0, ovf_a}, 32'd0);
    end

    // drop enable at gate_cnt=50 for 20 cycles
    repeat (50) tick();
    en_a   = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_a) vcount++;
    end
    chk("gap_no_valid", vcount, 0);
    chk("gap_freq_hold", {20'd0, freq_a}, 32'd10);
    en_a = 1'b1;
    wait_valid(0, 300, n);
    chk("reenter_latency", n, 101);
    chk("reenter_freq", {20'd0, freq_a}, 32'd10);

    // asynchronous reset between clock edges while valid is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq", {20'd0, freq_a}, 32'd0);
    chk("arst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("arst_valid", {31'd0, valid_a}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_valid(0, 200, n);
    chk("arst_resume_latency", n, 104);
    chk("arst_resume_freq", {20'd0, freq_a}, 32'd10);

    // 10000-cycle window: 5000 edges saturate, then 2500 edges
    en_a   = 1'b0;
    sq_per = 2;
    repeat (5) tick();
    en_b = 1'b1;
    wait_valid(1, 10100, n);
    chk("sat_latency", n, 10001);
    chk("sat_freq", {20'd0, freq_b}, 32'd4095);
    chk("sat_ovf", {31'd0, ovf_b}, 32'd1);
    sq_per = 4;
    wait_valid(1, 10100, n);
    wait_valid(1, 10100, n);
    chk("p4_spacing", n, 10000);
    chk("p4_freq", {20'd0, freq_b}, 32'd2500);
    chk("p4_ovf", {31'd0, ovf_b}, 32'd0);

    // terminal-cycle edge on the 4-bit instance
    en_b    = 1'b0;
    sq_per  = 0;
    sig_man = 1'b0;
    repeat (6) tick();
    en_c = 1'b1;
    for (int t = 1; t <= 301; t++) begin
      tick();
      if (t == 101) begin
        chk("term_add_valid", {31'd0, valid_c}, 32'd1);
        chk("term_add_freq", {28'd0, freq_c}, 32'd15);
        chk("term_add_ovf", {31'd0, ovf_c}, 32'd0);
      end
      if (t == 201) begin
        chk("term_sat_valid", {31'd0, valid_c}, 32'd1);
        chk("term_sat_freq", {28'd0, freq_c}, 32'd15);
        chk("term_sat_ovf", {31'd0, ovf_c}, 32'd1);
      end
      if (t == 301) begin
        chk("after_sat_valid", {31'd0, valid_c}, 32'd1);
        chk("after_sat_freq", {28'd0, freq_c}, 32'd0);
        chk("after_sat_ovf", {31'd0, ovf_c}, 32'd0);
      end
      sig_man = pat(t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
